booth_pp_gen_8x8: RTL and testbench



---
 rtl/booth_pkg.sv | 32 +++
 rtl/booth_row_sel.sv | 34 +++
 rtl/booth_pp_gen_8x8.sv | 120 ++++++++++++
 tb/tb_booth_pp_gen_8x8.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// ============================================================================
// Module      : booth_pkg
// Description : Shared types, widths and radix-4 Booth recoding helper for
//               the 8x8 partial-product generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package booth_pkg;

  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

  localparam int          PP_ROW0_W  = 11;
  localparam int          PP_ROWK_W  = 12;
  localparam logic [15:0] SEXT_CONST = 16'hAB00;

  // Window is {b[2k+1], b[2k], b[2k-1]}; all-ones and all-zeros are digit 0.
  function automatic booth_digit_t booth_recode(input logic [2:0] w);
    booth_digit_t d;
    d.one = w[1] ^ w[0];
    d.two = (w[2] & ~w[1] & ~w[0]) | (~w[2] & w[1] & w[0]);
    d.neg = w[2] & ~(w[1] & w[0]);
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/booth_row_sel.sv
// ============================================================================
// Module      : booth_row_sel
// Description : Selects 0 / +-a / +-2a for one Booth digit as a 9-bit
//               one's-complement row; the +1 of negation is carried separately.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_row_sel
  import booth_pkg::*;
(
  input  logic [7:0]   i_a,
  input  booth_digit_t i_digit,
  output logic [8:0]   o_sel,
  output logic         o_s
);

  logic [8:0] w_mag;

  always_comb begin
    w_mag = 9'd0;
    if (i_digit.one) begin
      w_mag = {i_a[7], i_a};
    end else if (i_digit.two) begin
      w_mag = {i_a, 1'b0};
    end
  end

  assign o_sel = i_digit.neg ? ~w_mag : w_mag;
  assign o_s   = o_sel[8];

endmodule

`default_nettype wire

// File: rtl/booth_pp_gen_8x8.sv
// ============================================================================
// Module      : booth_pp_gen_8x8
// Description : Two-stage elastic radix-4 Booth partial-product generator
//               feeding the 8x8 carry-save compression tree.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_pp_gen_8x8
  import booth_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_a,
  input  logic [7:0]           in_b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PP_ROW0_W-1:0] pp00,
  output logic [PP_ROWK_W-1:0] pp01,
  output logic [PP_ROWK_W-1:0] pp02,
  output logic [PP_ROWK_W-1:0] pp03,
  output logic                 sign3,
  output logic [TAG_W-1:0]     out_tag
);

  logic                   w_adv1;
  logic                   w_adv2;
  logic [8:0]             w_b_ext;
  booth_digit_t [3:0]     w_dig;
  logic [3:0][8:0]        w_sel;
  logic [3:0]             w_s;

  logic                   r_v1;
  logic [7:0]             r_a1;
  logic [TAG_W-1:0]       r_tag1;
  booth_digit_t [3:0]     r_dig1;

  logic                   r_v2;
  logic [PP_ROW0_W-1:0]   r_pp00;
  logic [PP_ROWK_W-1:0]   r_pp01;
  logic [PP_ROWK_W-1:0]   r_pp02;
  logic [PP_ROWK_W-1:0]   r_pp03;
  logic                   r_sign3;
  logic [TAG_W-1:0]       r_tag2;

  assign w_adv2   = ~r_v2 | out_ready;
  assign w_adv1   = ~r_v1 | w_adv2;
  assign in_ready = w_adv1;

  // Appending b[-1]=0 makes every digit window a plain 3-bit slice.
  assign w_b_ext = {in_b, 1'b0};

  generate
    for (genvar k = 0; k < 4; k++) begin : g_digit
      assign w_dig[k] = booth_recode(w_b_ext[2*k +: 3]);

      booth_row_sel u_sel (
        .i_a     (r_a1),
        .i_digit (r_dig1[k]),
        .o_sel   (w_sel[k]),
        .o_s     (w_s[k])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_a1   <= 8'd0;
      r_tag1 <= '0;
      r_dig1 <= '0;
    end else if (w_adv1) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_a1   <= in_a;
        r_tag1 <= in_tag;
        r_dig1 <= w_dig;
      end
    end
  end

  // Each row k>0 carries the deferred +1 of digit k-1 in its LSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2    <= 1'b0;
      r_pp00  <= '0;
      r_pp01  <= '0;
      r_pp02  <= '0;
      r_pp03  <= '0;
      r_sign3 <= 1'b0;
      r_tag2  <= '0;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_pp00  <= {~w_s[0], w_s[0], w_s[0], w_sel[0][7:0]};
        r_pp01  <= {1'b1, ~w_s[1], w_sel[1][7:0], 1'b0, r_dig1[0].neg};
        r_pp02  <= {1'b1, ~w_s[2], w_sel[2][7:0], 1'b0, r_dig1[1].neg};
        r_pp03  <= {1'b1, ~w_s[3], w_sel[3][7:0], 1'b0, r_dig1[2].neg};
        r_sign3 <= r_dig1[3].neg;
        r_tag2  <= r_tag1;
      end
    end
  end

  assign out_valid = r_v2;
  assign pp00      = r_pp00;
  assign pp01      = r_pp01;
  assign pp02      = r_pp02;
  assign pp03      = r_pp03;
  assign sign3     = r_sign3;
  assign out_tag   = r_tag2;

endmodule

`default_nettype wire

// File: tb/tb_booth_pp_gen_8x8.sv
// ============================================================================
// Module      : tb_booth_pp_gen_8x8
// Description : Self-checking bench for booth_pp_gen_8x8 with an arithmetic
//               Booth model, in-order scoreboard and directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_booth_pp_gen_8x8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = 8'd0;
  logic [7:0]  in_b = 8'd0;
  logic [3:0]  in_tag = 4'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [10:0] pp00;
  logic [11:0] pp01;
  logic [11:0] pp02;
  logic [11:0] pp03;
  logic        sign3;
  logic [3:0]  out_tag;

  int          errors = 0;
  int          checks = 0;
  int          n_acc  = 0;
  int          cycle  = 0;
  logic        throttle   = 1'b0;
  logic        hold_ready = 1'b0;
  logic [19:0] q[$];

  booth_pp_gen_8x8 #(.TAG_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pp00      (pp00),
    .pp01      (pp01),
    .pp02      (pp02),
    .pp03      (pp03),
    .sign3     (sign3),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    out_ready = throttle ? ($urandom_range(0, 15) != 0) : hold_ready;
  end

  // Booth digit value d = -2*b[2k+1] + b[2k] + b[2k-1]; row is |d|*a, inverted if d<0.
  function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                output logic [10:0] e00, output logic [11:0] e01,
                                output logic [11:0] e02, output logic [11:0] e03,
                                output logic es3);
    logic [8:0] bx;
    logic [8:0] sel [4];
    logic       neg [4];
    logic       s   [4];
    int         sa;
    bx = {b, 1'b0};
    sa = int'($signed(a));
    for (int k = 0; k < 4; k++) begin
      int d;
      int p;
      d = -2 * int'(bx[2*k+2]) + int'(bx[2*k+1]) + int'(bx[2*k]);
      neg[k] = (d < 0);
      p = ((d < 0) ? -d : d) * sa;
      sel[k] = p[8:0];
      if (neg[k]) sel[k] = ~sel[k];
      s[k] = sel[k][8];
    end
    e00 = {~s[0], s[0], s[0], sel[0][7:0]};
    e01 = {1'b1, ~s[1], sel[1][7:0], 1'b0, neg[0]};
    e02 = {1'b1, ~s[2], sel[2][7:0], 1'b0, neg[1]};
    e03 = {1'b1, ~s[3], sel[3][7:0], 1'b0, neg[2]};
    es3 = neg[3];
  endfunction

  function automatic logic [15:0] wsum(input logic [10:0] p0, input logic [11:0] p1,
                                       input logic [11:0] p2, input logic [11:0] p3,
                                       input logic s3);
    logic [15:0] t;
    t = {5'd0, p0} + {4'd0, p1} + ({4'd0, p2} << 2) + ({4'd0, p3} << 4)
        + ({15'd0, s3} << 6);
    return t;
  endfunction

  task automatic monitor_loop();
    logic        prev_stall;
    logic [51:0] held;
    logic [51:0] now_v;
    prev_stall = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      cycle++;
      now_v = {pp00, pp01, pp02, pp03, sign3, out_tag};
      if (rst) begin
        q.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (now_v != held) begin
            errors++;
            $display("FAIL stall_hold: got %h required %h", now_v, held);
          end
        end
        if (out_valid && out_ready) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL stale_out: emitted tag %h with nothing outstanding", out_tag);
          end else begin
            logic [19:0] e;
            logic [10:0] e00;
            logic [11:0] e01, e02, e03;
            logic        es3;
            logic [15:0] prod;
            e = q.pop_front();
            model(e[19:12], e[11:4], e00, e01, e02, e03, es3);
            if (now_v != {e00, e01, e02, e03, es3, e[3:0]}) begin
              errors++;
              $display("FAIL rows a=%h b=%h: got %h required %h", e[19:12], e[11:4],
                       now_v, {e00, e01, e02, e03, es3, e[3:0]});
            end
            prod = 16'(int'($signed(e[19:12])) * int'($signed(e[11:4])));
            checks++;
            if (wsum(pp00, pp01, pp02, pp03, sign3) != prod) begin
              errors++;
              $display("FAIL invariant a=%h b=%h: got %h required %h", e[19:12], e[11:4],
                       wsum(pp00, pp01, pp02, pp03, sign3), prod);
            end
          end
        end
        if (in_valid && in_ready) begin
          q.push_back({in_a, in_b, in_tag});
          n_acc++;
        end
        prev_stall = out_valid && !out_ready;
        held = now_v;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] t);
    logic acc;
    int   n;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_tag = t;
    n = 0;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", 32'(n >= 200), 32'd0);
  endtask

  task automatic direct(input logic [7:0] a, input logic [7:0] b, input logic [15:0] lit,
                        input string name);
    int n;
    send(a, b, 4'hA);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 8);
    chk({name, "_latency"}, 32'(n), 32'd2);
    chk({name, "_sum"}, 32'(wsum(pp00, pp01, pp02, pp03, sign3)), 32'(lit));
  endtask

  task automatic check_reset_state(input string name);
    @(negedge clk);
    chk({name, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({name, "_outputs"}, 32'(|{pp00, pp01, pp02, pp03, sign3, out_tag}), 32'd0);
  endtask

  initial begin
    int start;
    int c0;
    fork
      monitor_loop();
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state("reset");
    hold_ready = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors with hand-computed sums
    direct(8'd3, 8'd5, 16'd15, "a3_b5");
    chk("a3_b5_pp00", 32'(pp00), 32'h403);
    chk("a3_b5_negs", 32'({pp01[0], pp02[0], pp03[0], sign3}), 32'd0);
    drain();
    direct(8'h80, 8'h80, 16'h4000, "m128_m128");
    drain();
    direct(8'h7F, 8'h80, 16'hC080, "p127_m128");
    drain();
    direct(8'd5, 8'hFF, 16'hFFFB, "a5_bm1");
    chk("a5_bm1_sign3", 32'(sign3), 32'd0);
    chk("a5_bm1_neg0", 32'(pp01[0]), 32'd1);
    drain();

    // Back-to-back stream: one accept per cycle
    c0 = cycle;
    for (int i = 0; i < 20; i++) send(8'($urandom), 8'($urandom), 4'(i));
    chk("b2b_cycles", 32'(cycle - c0), 32'd20);
    drain();

    // Backpressure: only two pairs fit, outputs hold, nothing lost on release
    hold_ready = 1'b0;
    @(posedge clk);
    #1;
    start = n_acc;
    fork
      begin
        for (int i = 0; i < 6; i++) send(8'(17 * i + 3), 8'(251 - 29 * i), 4'(i + 4));
      end
      begin
        int n;
        n = 0;
        while (n_acc == start && n < 50) begin
          @(negedge clk);
          n++;
        end
        repeat (6) @(negedge clk);
        chk("stall_accepted", 32'(n_acc - start), 32'd2);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        hold_ready = 1'b1;
      end
    join
    drain();
    chk("stall_total", 32'(n_acc - start), 32'd6);

    // Reset with both stages occupied
    hold_ready = 1'b0;
    @(posedge clk);
    #1;
    send(8'h11, 8'h22, 4'h1);
    send(8'h33, 8'h44, 4'h2);
    @(negedge clk);
    chk("flush_pre_full", 32'({out_valid, in_ready}), 32'b10);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state("flush");
    hold_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("flush_no_stale", 32'(out_valid), 32'd0);

    // Exhaustive sweep under random throttling
    throttle = 1'b1;
    for (int i = 0; i < 65536; i++) send(8'(i), 8'(i >> 8), 4'(i));
    throttle = 1'b0;
    hold_ready = 1'b1;
    drain();
    chk("sweep_count", 32'(n_acc), 32'(n_acc - start + start));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
